ring_acc_quant: RTL and testbench
=================================

RING_ACC_QUANT -- requirements
Module: ring_acc_quant

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: feature/output element width (tracks `BITWIDTH).
REQ-002 SHALL have parameter N, default 4: ring partition factor (tracks `N).
REQ-003 SHALL have parameter BW_MATMUL, default 2*BITWIDTH+$clog2(4/N): width of one matmul product lane.
REQ-004 SHALL have parameter BW_ACC, default BW_MATMUL+8: accumulator lane width (256 beats headroom).
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: in_data/in_last valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, 4*BW_MATMUL: four signed lanes, lane0 in the MSBs (matmul_out packing).
REQ-010 SHALL have port in_last, input, 1: final beat of the current accumulation group.
REQ-011 SHALL have port shift, input, 5: right-shift amount for requantization, 0..BW_ACC-1.
REQ-012 SHALL have port relu_en, input, 1: clamp negative results to 0.
REQ-013 SHALL have port out_valid, output, 1: out_data holds a result.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-015 SHALL have port out_data, output, 4*BITWIDTH: four signed quantized lanes, lane0 in the MSBs.
REQ-016 SHALL have port out_sat, output, 4: per-lane flag, result was saturated.

Function
REQ-017 SHALL accept a beat on the rising edge when in_valid && in_ready.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (combinational, no out_ready->in_ready register).
REQ-019 SHALL sign-extend each lane to BW_ACC and add it to the lane accumulator on every accepted beat.
REQ-020 SHALL use FSM states IDLE (accumulator empty) and ACC (partial sum held).
REQ-021 Transitions: IDLE->ACC on an accepted non-last beat; ACC->IDLE on an accepted closing beat; all other cycles hold the state.
REQ-022 A closing beat is an accepted beat with in_last=1, or the 256th accepted beat of a group (8-bit beat counter reaching 255); the forced close SHALL behave identically to in_last.
REQ-023 On a closing beat, the block SHALL form sum = acc + beat per lane and clear acc and the beat counter in the same edge.
REQ-024 The block SHALL register the quantized sum into out_data, assert out_valid, and drive the per-lane out_sat bits on that same edge: latency is 1 cycle from closing beat to out_valid.
REQ-025 Quantization per lane: if shift>0, add 2^(shift-1); then arithmetic right shift by shift; then if relu_en, replace negatives with 0; then saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-026 out_sat bit SHALL be 1 iff the saturation step in REQ-025 changed the value.
REQ-027 shift and relu_en SHALL be sampled on the closing beat only.
REQ-028 out_valid SHALL stay high and out_data/out_sat stable until out_valid && out_ready.
REQ-029 On the handshake, out_valid SHALL drop next cycle unless a closing beat is accepted in the same cycle, in which case the new result SHALL load with no bubble.
REQ-030 Non-closing beats SHALL accumulate while out_valid is high and in_ready is high.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously clear accumulators, beat counter, out_valid, out_data and out_sat to 0, with FSM=IDLE.
REQ-032 Reset mid-group SHALL discard the partial sum; the first beat after release starts a new group.

Structure
REQ-033 BITWIDTH, N, BW_MATMUL and BW_ACC derivations and the FSM state encoding SHALL live in the shared accelerator package.
REQ-034 Per-lane round/shift/relu/saturate SHALL be one combinational sub-module, requant_lane, instantiated 4 times.

Verification
REQ-035 Bench SHALL cover: single beat, in_last=1, lanes {300,-300,3,-3}, shift=0, relu_en=0 -> out_data {127,-128,3,-3}, out_sat=4'b1100, out_valid one cycle later.
REQ-036 Bench SHALL cover: 3 beats, all lanes 5, shift=2 -> sum 15, (15+2)>>2 = 4 on every lane, out_sat=0.
REQ-037 Bench SHALL cover: lanes {-20,20,-1,0}, in_last, shift=0, relu_en=1 -> {0,20,0,0}.
REQ-038 Bench SHALL cover: out_ready=0 for 5 cycles after a result -> out_data stable and in_ready=0; then out_ready=1 with a simultaneous closing beat -> the next result loads back-to-back.
REQ-039 Bench SHALL cover: 256 beats of lane value 1 with in_last=0 -> forced close, sum 256 with shift=1 -> 128 saturates to 127, out_sat=1; beat 257 starts a new group.
REQ-040 Bench SHALL cover: rst_n pulsed low after 2 of 4 beats -> outputs 0; 4 fresh beats of 1 with in_last on the 4th -> 4.

Source files
------------

// File: rtl/ring_acc_quant_pkg.sv
// ring_acc_quant_pkg
//   Shared accelerator definitions for the ring accumulate/requantize block.
//   Holds the default element width, the ring partition factor, the width
//   derivations for the matmul product lane and the accumulator lane, and
//   the FSM state encoding.
package ring_acc_quant_pkg;

  localparam int BITWIDTH_DEF = 8;
  localparam int N_DEF        = 4;

  // Eight guard bits let 256 full-scale beats accumulate without wrapping.
  localparam int ACC_HEADROOM = 8;

  localparam int LANES = 4;

  // Product lane width: two BITWIDTH operands plus the growth from summing
  // 4/N partial products inside one ring partition.
  function automatic int bw_matmul(input int bitwidth, input int n);
    return 2 * bitwidth + $clog2(4 / n);
  endfunction

  function automatic int bw_acc(input int bw_mm);
    return bw_mm + ACC_HEADROOM;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,  // accumulator empty
    ACC  = 1'b1   // partial sum held
  } acc_state_e;

endpackage

// File: rtl/ring_acc_quant_requant_lane.sv
// requant_lane
//   Combinational requantizer for one accumulator lane:
//   round-half-up, arithmetic right shift, optional ReLU, then saturate to a
//   signed BITWIDTH result.
// Ports:
//   sum_in  - signed accumulated lane value (BW_ACC bits)
//   shift   - right-shift amount, 0..BW_ACC-1
//   relu_en - replace negative shifted values with 0
//   q_out   - signed quantized result (BITWIDTH bits)
//   sat_out - 1 when the saturation step changed the value
module requant_lane #(
  parameter int BITWIDTH = 8,
  parameter int BW_ACC   = 24
) (
  input  logic signed [BW_ACC-1:0]   sum_in,
  input  logic        [4:0]          shift,
  input  logic                       relu_en,
  output logic        [BITWIDTH-1:0] q_out,
  output logic                       sat_out
);

  // One extra bit so that adding the rounding constant cannot overflow.
  localparam logic signed [BW_ACC:0] MAX_V   = (BW_ACC+1)'((1 << (BITWIDTH-1)) - 1);
  localparam logic signed [BW_ACC:0] MIN_V   = ~MAX_V;
  localparam logic signed [BW_ACC:0] RND_ONE = (BW_ACC+1)'(1);

  logic signed [BW_ACC:0] widened;
  logic signed [BW_ACC:0] rnd;
  logic signed [BW_ACC:0] rounded;
  logic signed [BW_ACC:0] shifted;
  logic signed [BW_ACC:0] relued;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    rnd     = '0;
    q_out   = '0;
    sat_out = 1'b0;

    widened = (BW_ACC+1)'(sum_in);
    if (shift != 5'd0) begin
      rnd = RND_ONE << (shift - 5'd1);
    end
    rounded = widened + rnd;
    shifted = rounded >>> shift;
    relued  = (relu_en && (shifted < 0)) ? '0 : shifted;

    if (relued > MAX_V) begin
      q_out   = MAX_V[BITWIDTH-1:0];
      sat_out = 1'b1;
    end else if (relued < MIN_V) begin
      q_out   = MIN_V[BITWIDTH-1:0];
      sat_out = 1'b1;
    end else begin
      q_out   = relued[BITWIDTH-1:0];
    end
  end

endmodule

// File: rtl/ring_acc_quant.sv
// ring_acc_quant
//   Accumulates four signed matmul product lanes over a group of beats and,
//   on the group's closing beat, requantizes the sum into four signed
//   BITWIDTH results held in a single-entry output register.
//   A group closes on in_last or on its 256th beat.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid/in_ready   - input handshake
//   in_data             - four signed BW_MATMUL lanes, lane0 in the MSBs
//   in_last             - final beat of the current group
//   shift, relu_en      - requantization controls, sampled on the closing beat
//   out_valid/out_ready - output handshake
//   out_data            - four signed BITWIDTH lanes, lane0 in the MSBs
//   out_sat             - per-lane saturation flag, bit 3 = lane0
module ring_acc_quant
  import ring_acc_quant_pkg::*;
#(
  parameter int BITWIDTH  = BITWIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int BW_MATMUL = bw_matmul(BITWIDTH, N),
  parameter int BW_ACC    = bw_acc(BW_MATMUL)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BW_MATMUL-1:0] in_data,
  input  logic                      in_last,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  output logic [LANES-1:0]          out_sat
);

  acc_state_e state_q, state_d;

  logic [LANES-1:0][BW_ACC-1:0] acc_q, acc_d;
  logic [LANES-1:0][BW_ACC-1:0] sum;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [LANES*BITWIDTH-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0]             out_sat_q, out_sat_d;

  logic [LANES*BITWIDTH-1:0]    q_all;
  logic [LANES-1:0]             sat_all;

  logic accept;
  logic closing;

  // The output register frees up in the same cycle it is drained, so the
  // ready path is purely combinational from out_ready.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // The 256th beat closes the group so the 8 guard bits never overflow.
  assign closing  = accept && (in_last || (cnt_q == 8'd255));

  // Per-lane running sum including the current beat; this is also the
  // value requantized on a closing beat.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i] = acc_q[i] + BW_ACC'($signed(in_data[(LANES-1-i)*BW_MATMUL +: BW_MATMUL]));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .BITWIDTH (BITWIDTH),
      .BW_ACC   (BW_ACC)
    ) u_requant_lane (
      .sum_in  (sum[g]),
      .shift   (shift),
      .relu_en (relu_en),
      .q_out   (q_all[(LANES-1-g)*BITWIDTH +: BITWIDTH]),
      .sat_out (sat_all[LANES-1-g])
    );
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = closing ? IDLE : ACC;
    end
  end

  // Datapath next state.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (closing) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = q_all;
      out_sat_d   = sat_all;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator lanes are plain registers, not a RAM, so they
      // are cleared by reset; a partial group must not survive it.
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_ring_acc_quant.sv
// Directed testbench for ring_acc_quant with default parameters
// (BITWIDTH=8, BW_MATMUL=16, BW_ACC=24).
module tb_ring_acc_quant;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [4:0]  shift;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;

  int checks = 0;
  int errors = 0;

  ring_acc_quant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  // Present one beat and let one rising edge pass; outputs are then sampled
  // 1 time unit after that edge.
  task automatic beat(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    shift     = 5'd0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++; if (out_sat !== 4'h0) begin errors++; $display("FAIL reset_out_sat got %b exp 0000", out_sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // {300,-300,3,-3}, shift 0 -> {127,-128,3,-3}, lanes 0 and 1 saturate.
  task automatic test_saturate();
    shift   = 5'd0;
    relu_en = 1'b0;
    in_valid = 1'b1;
    in_data  = pack4(300, -300, 3, -3);
    in_last  = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_pre_valid got %b exp 0", out_valid); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h7f8003fd) begin errors++; $display("FAIL sat_data got %h exp 7f8003fd", out_data); end
    checks++; if (out_sat !== 4'b1100) begin errors++; $display("FAIL sat_flags got %b exp 1100", out_sat); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drop got %b exp 0", out_valid); end
  endtask

  // Three beats of 5 -> 15; (15+2)>>2 = 4. shift is only honoured on the
  // closing beat, so an unrelated value is presented on the first two.
  task automatic test_round();
    relu_en = 1'b0;
    shift   = 5'd7;
    beat(pack4(5, 5, 5, 5), 1'b0);
    beat(pack4(5, 5, 5, 5), 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_partial_valid got %b exp 0", out_valid); end
    shift = 5'd2;
    beat(pack4(5, 5, 5, 5), 1'b1);
    shift = 5'd0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h04040404) begin errors++; $display("FAIL round_data got %h exp 04040404", out_data); end
    checks++; if (out_sat !== 4'b0000) begin errors++; $display("FAIL round_flags got %b exp 0000", out_sat); end
  endtask

  // {-20,20,-1,0} with ReLU -> {0,20,0,0}.
  task automatic test_relu();
    shift   = 5'd0;
    relu_en = 1'b1;
    beat(pack4(-20, 20, -1, 0), 1'b1);
    relu_en = 1'b0;
    checks++; if (out_data !== 32'h00140000) begin errors++; $display("FAIL relu_data got %h exp 00140000", out_data); end
    checks++; if (out_sat !== 4'b0000) begin errors++; $display("FAIL relu_flags got %b exp 0000", out_sat); end
    idle();
  endtask

  // Hold a result for 5 cycles with beats offered that must not be taken,
  // then drain it while a closing beat loads the next result with no bubble.
  task automatic test_back_to_back();
    int stall_bad;
    stall_bad = 0;
    out_ready = 1'b0;
    beat(pack4(1, 2, 3, 4), 1'b1);
    for (int i = 0; i < 5; i++) begin
      beat(pack4(100, 100, 100, 100), 1'b0);
      if (out_valid !== 1'b1 || out_data !== 32'h01020304 || in_ready !== 1'b0) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles %0d exp 0 (data %h ready %b)", stall_bad, out_data, in_ready); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pack4(10, 20, 30, 40);
    in_last   = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h0a141e28) begin errors++; $display("FAIL b2b_data got %h exp 0a141e28", out_data); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b exp 0", out_valid); end
  endtask

  // 256 beats of 1 with in_last low force a close: (256+1)>>1 = 128 -> 127.
  // The 257th beat opens a fresh group.
  task automatic test_forced_close();
    shift = 5'd1;
    for (int i = 0; i < 255; i++) begin
      beat(pack4(1, 1, 1, 1), 1'b0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL force_early_valid got %b exp 0", out_valid); end
    beat(pack4(1, 1, 1, 1), 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL force_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h7f7f7f7f) begin errors++; $display("FAIL force_data got %h exp 7f7f7f7f", out_data); end
    checks++; if (out_sat !== 4'b1111) begin errors++; $display("FAIL force_flags got %b exp 1111", out_sat); end
    shift = 5'd0;
    beat(pack4(2, 2, 2, 2), 1'b1);
    checks++; if (out_data !== 32'h02020202) begin errors++; $display("FAIL force_next_data got %h exp 02020202", out_data); end
    checks++; if (out_sat !== 4'b0000) begin errors++; $display("FAIL force_next_flags got %b exp 0000", out_sat); end
  endtask

  // Reset after 2 of 4 beats discards the partial sum.
  task automatic test_reset_mid();
    shift = 5'd0;
    beat(pack4(1, 1, 1, 1), 1'b0);
    beat(pack4(1, 1, 1, 1), 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h exp 00000000", out_data); end
    checks++; if (out_sat !== 4'h0) begin errors++; $display("FAIL rstmid_flags got %b exp 0000", out_sat); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(pack4(1, 1, 1, 1), 1'b0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid got %b exp 0", out_valid); end
    beat(pack4(1, 1, 1, 1), 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_res_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h04040404) begin errors++; $display("FAIL rstmid_res_data got %h exp 04040404", out_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_round();
    test_relu();
    test_back_to_back();
    test_forced_close();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
